// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues one memory request per fetchStart
// and latches the returned word, with a sticky timeout fault.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchStart,
  input  logic        pcEn,
  input  logic        pcIncOrSet,
  input  logic [15:0] pcTarget,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memAck,
  input  logic [15:0] memData,
  output logic [15:0] instruction,
  output logic        instrValid,
  output logic        busy,
  output logic [15:0] pc,
  output logic        fault
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StFault} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [15:0]     pc_q, pc_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= 16'h0000;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        if (fetchStart) begin
          // Captures the pre-update pc even when pcEn fires on the same edge.
          addr_d  = pc_q;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        // An ack on the last allowed cycle wins over the timeout.
        if (memAck) begin
          instr_d = memData;
          valid_d = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          cnt_d   = cnt_q + 1'b1;
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFault: ;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (pcEn) begin
      pc_d = pcIncOrSet ? pcTarget : pc_q + 16'd1;
    end
  end

  assign memReq      = (state_q == StReq);
  assign busy        = memReq;
  assign memAddr     = addr_q;
  assign instruction = instr_q;
  assign instrValid  = valid_q;
  assign fault       = fault_q;
  assign pc          = pc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 8, meaning: maximum cycles the unit waits in REQ for memAck before faulting.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetchStart  input  1  one-cycle pulse from the control FSM in its IF state, requesting a fetch.
REQ-006 pcEn  input  1  PC update enable.
REQ-007 pcIncOrSet  input  1  0 = PC+1, 1 = load pcTarget.
REQ-008 pcTarget  input  16  branch/jump target.
REQ-009 memReq  output  1  instruction-memory request.
REQ-010 memAddr  output  16  instruction-memory address.
REQ-011 memAck  input  1  memory response strobe; memData is valid in the same cycle.
REQ-012 memData  input  16  instruction word from memory.
REQ-013 instruction  output  16  latched instruction word to the control FSM and datapath.
REQ-014 instrValid  output  1  instruction holds a freshly fetched word.
REQ-015 busy  output  1  fetch in progress.
REQ-016 pc  output  16  current program counter.
REQ-017 fault  output  1  sticky fetch-timeout flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ, FAULT.
REQ-019 In IDLE, fetchStart=1 SHALL capture pc into memAddr and move to REQ on the next edge.
REQ-020 memReq SHALL be 1 exactly while in REQ; busy SHALL equal memReq.
REQ-021 memAddr SHALL remain stable for the whole time memReq=1, regardless of pcEn activity.
REQ-022 In REQ, memAck=1 SHALL load memData into instruction, set instrValid=1 and return to IDLE, all on the same edge.
REQ-023 Minimum latency: fetchStart at cycle N, memReq at N+1, memAck at N+1 gives instruction/instrValid valid at N+2.
REQ-024 instrValid SHALL clear on the edge that accepts the next fetchStart; otherwise it holds.
REQ-025 instruction SHALL hold its value until the next accepted memAck.
REQ-026 A cycle counter SHALL clear on REQ entry and increment each REQ cycle without memAck.
REQ-027 After TIMEOUT consecutive REQ cycles without memAck, the unit SHALL enter FAULT, set fault=1, and drop memReq.
REQ-028 A memAck in the same cycle the counter reaches TIMEOUT SHALL be accepted; it SHALL NOT fault.
REQ-029 FAULT SHALL be exited only by reset; in FAULT, fetchStart and memAck SHALL be ignored and instruction SHALL hold.
REQ-030 fetchStart while in REQ SHALL be ignored (no re-capture, no counter clear).
REQ-031 memAck outside REQ SHALL be ignored.
REQ-032 pcEn=1 SHALL update pc on the edge in any state: pcIncOrSet=0 gives pc+1 modulo 2^16 (16'hFFFF wraps to 16'h0000); pcIncOrSet=1 gives pcTarget.
REQ-033 If fetchStart and pcEn are both 1 in the same cycle, memAddr SHALL capture the pre-update pc.
REQ-034 pcEn=0 SHALL hold pc.

Reset
REQ-035 reset=1 at an edge SHALL set pc=RESET_PC, state=IDLE, memReq=0, memAddr=16'h0000, instruction=16'h0000, instrValid=0, fault=0, and counter=0.
REQ-036 reset SHALL take priority over every other input, including mid-REQ; an in-flight memAck coincident with reset SHALL be discarded.

Verification
REQ-037 Reset, fetchStart at N, memAck at N+1 with memData=16'h5A3C -> memAddr=16'h0000 while memReq=1; at N+2 instruction=16'h5A3C, instrValid=1, busy=0.
REQ-038 fetchStart, memAck delayed 5 cycles, pcEn=1 with pcIncOrSet=1 and pcTarget=16'h0040 during the wait -> memAddr stays at the old pc; pc=16'h0040 after that edge; word captured on ack.
REQ-039 fetchStart, no memAck for 8 cycles (TIMEOUT=8) -> fault=1, memReq=0; later fetchStart and memAck change nothing; after reset, fault=0.
REQ-040 pc=16'hFFFF, pcEn=1, pcIncOrSet=0 -> pc=16'h0000; pcEn and fetchStart in the same cycle with pc=16'h0010 -> memAddr=16'h0010, pc=16'h0011.
REQ-041 Reset asserted mid-REQ together with memAck -> memReq=0 next cycle, instruction=16'h0000, instrValid=0, pc=RESET_PC.
REQ-042 Second fetchStart while busy, and memAck while IDLE -> both ignored; memAddr, counter and instruction unchanged.
